cmp_share_arbiter: RTL and testbench

- Shares one pipelined FP less-or-equal comparator among NREQ requesters.
- The comparator is the FPSub-based unit in the 11_22 format: 36-bit operands made of exn[35:34], sign[33], exp[32:22] and mant[21:0].
- Grants requesters round-robin, at most one issue per cycle.
- Tracks each in-flight operation's requester tag through a shift pipeline matched to the comparator latency, then steers each result to its requester's response register.
- Sits between the slab-test stages (x/y/z tmin/tmax checks) of the Ray-AABB unit and a single comparator instance.

---
 rtl/cmp_share_arbiter.sv | 109 ++++++++++
 tb/tb_cmp_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arbiter.sv
// Round-robin sharing of one pipelined FP less-or-equal comparator among NREQ requesters.
// Each issued operation's requester tag rides a shift pipe so the comparator result is steered back.
module cmp_share_arbiter #(
    parameter int WIDTH   = 35,
    parameter int NREQ    = 4,
    parameter int TAGW    = 2,
    parameter int CMP_LAT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*(WIDTH+1)-1:0]   req_a,
    input  logic [NREQ*(WIDTH+1)-1:0]   req_b,
    output logic [NREQ-1:0]             req_ready,
    output logic [WIDTH:0]              cmp_a,
    output logic [WIDTH:0]              cmp_b,
    input  logic                        cmp_le,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [NREQ-1:0]             rsp_le,
    input  logic [NREQ-1:0]             rsp_ready,
    output logic                        busy
);
    localparam int unsigned OPW = WIDTH + 1;
    localparam int unsigned NR  = NREQ;
    localparam int unsigned LAT = CMP_LAT;

    logic [TAGW-1:0]  r_ptr;
    logic [NREQ-1:0]  r_out;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [NREQ-1:0]  r_rsp_le;
    logic [WIDTH:0]   r_cmp_a;
    logic [WIDTH:0]   r_cmp_b;
    // Stage 0 covers the cmp_a/cmp_b register cycle, so the pipe is LAT+1 deep.
    logic [LAT:0]     r_pv;
    logic [TAGW-1:0]  r_pt [LAT+1];

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_grant;
    logic [NREQ-1:0]  w_ret;
    logic             w_gany;
    logic [TAGW-1:0]  w_gsel;
    logic [TAGW-1:0]  w_cand;
    logic [WIDTH:0]   w_opa;
    logic [WIDTH:0]   w_opb;

    assign w_elig = req_valid & ~r_out & {NREQ{rst}};

    always_comb begin
        w_gany  = 1'b0;
        w_gsel  = '0;
        w_cand  = '0;
        w_grant = '0;
        w_opa   = '0;
        w_opb   = '0;
        for (int unsigned off = 0; off < NR; off++) begin
            w_cand = TAGW'((32'(r_ptr) + off) % NR);
            if (!w_gany && w_elig[w_cand]) begin
                w_gany          = 1'b1;
                w_gsel          = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NR; i++) begin
            if (w_grant[i]) begin
                w_opa = req_a[i*OPW +: OPW];
                w_opb = req_b[i*OPW +: OPW];
            end
        end
    end

    always_comb begin
        w_ret = '0;
        if (r_pv[LAT]) w_ret[r_pt[LAT]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_out       <= '0;
            r_rsp_valid <= '0;
            r_rsp_le    <= '0;
            r_cmp_a     <= '0;
            r_cmp_b     <= '0;
            r_pv        <= '0;
            for (int unsigned s = 0; s <= LAT; s++) r_pt[s] <= '0;
        end else begin
            if (w_gany) begin
                r_ptr   <= TAGW'((32'(w_gsel) + 1) % NR);
                r_cmp_a <= w_opa;
                r_cmp_b <= w_opb;
            end
            r_pv    <= {r_pv[LAT-1:0], w_gany};
            r_pt[0] <= w_gsel;
            for (int unsigned s = 1; s <= LAT; s++) r_pt[s] <= r_pt[s-1];
            r_out       <= (r_out & ~(r_rsp_valid & rsp_ready)) | w_grant;
            r_rsp_valid <= (r_rsp_valid & ~rsp_ready) | w_ret;
            r_rsp_le    <= (r_rsp_le & ~w_ret) | (w_ret & {NREQ{cmp_le}});
        end
    end

    assert property (@(posedge clk) disable iff (!rst) r_pv[LAT] |-> (32'(r_pt[LAT]) < NR));

    assign req_ready = w_grant;
    assign cmp_a     = r_cmp_a;
    assign cmp_b     = r_cmp_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_le    = r_rsp_le;
    assign busy      = |r_out;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: cycle-level scheduling model plus directed scenarios.
// The comparator is stubbed as a CMP_LAT-deep pipe of a behavioural FP <= function.
module tb_cmp_share_arbiter;
    localparam int W  = 35;
    localparam int N  = 4;
    localparam int T  = 2;
    localparam int L  = 4;
    localparam int OW = W + 1;
    localparam logic [35:0] ONE  = 36'h4FFC00000;
    localparam logic [35:0] TWO  = 36'h500000000;
    localparam logic [35:0] MONE = 36'h6FFC00000;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*OW-1:0]   req_a;
    logic [N*OW-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic [OW-1:0]     cmp_a;
    logic [OW-1:0]     cmp_b;
    logic              cmp_le;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_le;
    logic [N-1:0]      rsp_ready;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    cmp_share_arbiter #(.WIDTH(W), .NREQ(N), .TAGW(T), .CMP_LAT(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_le(cmp_le),
        .rsp_valid(rsp_valid), .rsp_le(rsp_le), .rsp_ready(rsp_ready), .busy(busy)
    );

    function automatic logic fp_le(input logic [35:0] a, input logic [35:0] b);
        if (a[33] != b[33]) return a[33];
        if (!a[33]) return a[32:0] <= b[32:0];
        return a[32:0] >= b[32:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // comparator stub
    logic [L-1:0] pipe     = '0;
    logic         tog      = 1'b0;
    logic         tog_mode = 1'b0;
    always @(posedge clk) begin
        pipe <= {pipe[L-2:0], fp_le(cmp_a, cmp_b)};
        tog  <= ~tog;
    end
    assign cmp_le = tog_mode ? tog : pipe[L-1];

    // model state
    int           m_ptr;
    logic [N-1:0] m_out, m_rv, m_rle, m_lev;
    int           m_due [N];
    logic [35:0]  m_cmpa, m_cmpb;
    logic [N-1:0] eg;
    int           gk;
    int           g_idx [$];
    int           g_cyc [$];
    int           cons_cyc [N];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_cmp_a", cmp_a, 0);
            chk("rst_cmp_b", cmp_b, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_le", rsp_le, 0);
            chk("rst_busy", busy, 0);
            m_ptr = 0; m_out = '0; m_rv = '0; m_rle = '0; m_lev = '0;
            m_cmpa = '0; m_cmpb = '0;
            for (int i = 0; i < N; i++) m_due[i] = -1;
        end else begin
            eg = '0; gk = -1;
            for (int off = 0; off < N; off++)
                if (gk < 0 && req_valid[(m_ptr+off)%N] && !m_out[(m_ptr+off)%N]) gk = (m_ptr+off)%N;
            if (gk >= 0) eg[gk] = 1'b1;
            chk("req_ready", req_ready, eg);
            chk("cmp_a", cmp_a, m_cmpa);
            chk("cmp_b", cmp_b, m_cmpb);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_le", rsp_le, m_rle);
            chk("busy", busy, |m_out);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin g_idx.push_back(i); g_cyc.push_back(cyc); break; end
            end
            for (int i = 0; i < N; i++) if (rsp_valid[i] && rsp_ready[i]) cons_cyc[i] = cyc;
            // advance model to the next cycle
            for (int i = 0; i < N; i++)
                if (m_rv[i] && rsp_ready[i]) begin m_rv[i] = 1'b0; m_out[i] = 1'b0; end
            if (gk >= 0) begin
                m_out[gk] = 1'b1;
                m_due[gk] = cyc + L + 2;
                m_lev[gk] = fp_le(req_a[gk*OW +: OW], req_b[gk*OW +: OW]);
                m_cmpa    = req_a[gk*OW +: OW];
                m_cmpb    = req_b[gk*OW +: OW];
                m_ptr     = (gk + 1) % N;
            end
            for (int i = 0; i < N; i++)
                if (m_due[i] == cyc + 1) begin m_rv[i] = 1'b1; m_rle[i] = m_lev[i]; m_due[i] = -1; end
        end
    end

    logic [35:0] opa_t [N];
    logic [35:0] opb_t [N];
    logic        le_t  [N];

    task automatic load_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*OW +: OW] = opa_t[i];
            req_b[i*OW +: OW] = opb_t[i];
        end
    endtask

    task automatic wait_grant(input int r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic reset_begin();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic reset_end();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic single(input int r, input logic [35:0] a, input logic [35:0] b, input logic exp);
        bit ok;
        req_a[r*OW +: OW] = a;
        req_b[r*OW +: OW] = b;
        req_valid[r] = 1'b1;
        wait_grant(r, ok);
        chk("single_grant", ok, 1);
        @(posedge clk); #1 req_valid[r] = 1'b0;
        @(negedge clk); chk("single_cmp_a", cmp_a, a);
        repeat (4) @(negedge clk);
        chk("single_rsp_early", rsp_valid[r], 0);
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid[r], 1);
        chk("single_rsp_le", rsp_le[r], exp);
        @(posedge clk); #1 rsp_ready[r] = 1'b1;
        @(posedge clk); #1 rsp_ready[r] = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int c0, c1, c2, c3, g2c, bad;
        rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        opa_t = '{ONE, TWO, MONE, ONE};
        opb_t = '{TWO, ONE, ONE, MONE};
        le_t  = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < N; i++) chk("fp_model_tab", fp_le(opa_t[i], opb_t[i]), le_t[i]);
        chk("fp_model_eq", fp_le(ONE, ONE), 1);

        // single requester, three operand patterns
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        single(0, ONE, TWO, 1'b1);
        single(1, TWO, ONE, 1'b0);
        single(2, ONE, ONE, 1'b1);

        // round-robin from reset
        reset_begin();
        load_ops(); req_valid = '1; rsp_ready = '1;
        g_idx.delete(); g_cyc.delete();
        reset_end();
        repeat (20) @(posedge clk);
        chk("rr_log_size", g_idx.size() >= 5, 1);
        if (g_idx.size() >= 5) begin
            for (int i = 0; i < 4; i++) chk("rr_order", g_idx[i], i);
            for (int i = 1; i < 4; i++) chk("rr_consec", g_cyc[i] - g_cyc[i-1], 1);
            chk("rr_regrant_idx", g_idx[4], 0);
            chk("rr_regrant_gap", g_cyc[4] - g_cyc[0], 7);
        end
        #1 req_valid = '0;
        repeat (10) @(posedge clk);

        // backpressure on requester 2
        reset_begin();
        req_valid = '1; rsp_ready = 4'b1011;
        g_idx.delete(); g_cyc.delete();
        for (int i = 0; i < N; i++) cons_cyc[i] = -1;
        reset_end();
        repeat (26) @(posedge clk);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        foreach (g_idx[i]) case (g_idx[i]) 0: c0++; 1: c1++; 2: c2++; default: c3++; endcase
        chk("bp_hold_grants2", c2, 1);
        chk("bp_others_served", (c0 >= 3) && (c1 >= 3) && (c3 >= 3), 1);
        #1 rsp_ready[2] = 1'b1;
        @(posedge clk); #1 rsp_ready[2] = 1'b0;
        repeat (10) @(posedge clk);
        c2 = 0; g2c = -1;
        foreach (g_idx[i]) if (g_idx[i] == 2) begin c2++; g2c = g_cyc[i]; end
        chk("bp_regrant_count", c2, 2);
        chk("bp_consumed", cons_cyc[2] >= 0, 1);
        chk("bp_regrant_after", g2c > cons_cyc[2], 1);
        #1 req_valid = '0; rsp_ready = '1;
        repeat (10) @(posedge clk);

        // asynchronous reset with two operations in flight
        reset_begin();
        rsp_ready = '0; req_valid = 4'b0011;
        reset_end();
        @(posedge clk); #1 req_valid = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 0);
        chk("arst_cmp_a", cmp_a, 0);
        chk("arst_cmp_b", cmp_b, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        tog_mode = 1'b1;
        reset_end();
        g_idx.delete(); g_cyc.delete();
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (|rsp_valid) bad++;
        end
        chk("arst_no_rsp", bad, 0);
        tog_mode = 1'b0;
        @(posedge clk); #1 req_valid = '1; rsp_ready = '1;
        repeat (3) @(posedge clk);
        chk("arst_first_grant_seen", g_idx.size() >= 1, 1);
        if (g_idx.size() >= 1) chk("arst_first_grant", g_idx[0], 0);
        #1 req_valid = '0;
        repeat (10) @(posedge clk);

        // pointer wrap between requesters 3 and 0
        reset_begin();
        req_valid = 4'b1000; rsp_ready = 4'b1001;
        g_idx.delete(); g_cyc.delete();
        reset_end();
        wait_grant(3, ok);
        chk("wrap_first_grant", ok, 1);
        @(posedge clk); #1 req_valid = 4'b1001;
        @(negedge clk); chk("wrap_busy", busy, 1);
        repeat (30) @(posedge clk);
        chk("wrap_log_size", g_idx.size() >= 6, 1);
        if (g_idx.size() >= 6)
            for (int i = 0; i < 6; i++) chk("wrap_order", g_idx[i], (i % 2 == 0) ? 3 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
